ahb_sram_slave: RTL
===================

Name: ahb_sram_slave

Overview:
Parametrised AHB-Lite memory slave, successor to the fixed 1K×32 slave memory. Adds configurable data/address width, HSIZE byte-lane writes, a programmable read-only window, and fixed plus externally requested wait states. Adds a correct two-cycle ERROR response and write-to-read forwarding. Sits on the AHB decoder/mux as a leaf slave in the VIP test system.

Parameters:
ADDR_WIDTH, 12, byte-address width of HADDR; depth = 2**ADDR_WIDTH / (DATA_WIDTH/8) words
DATA_WIDTH, 32, HWDATA/HRDATA width; one of 32 or 64
RO_BASE, 'h000, first byte address of read-only window (inclusive)
RO_LIMIT, 'h00F, last byte address of read-only window (inclusive)
WAIT_STATES, 0, fixed wait cycles inserted in every data phase (0..7)

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset, asynchronous assert, active-low
HSEL  in  1  slave select
HADDR  in  ADDR_WIDTH  byte address
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  in  1  1=write
HSIZE  in  3  transfer size, 2**HSIZE bytes
HWDATA  in  DATA_WIDTH  write data (data phase)
HREADYIN  in  1  bus HREADY from mux
wait_req  in  1  external stall request, sampled each data-phase cycle
HRDATA  out  DATA_WIDTH  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0, pending-write valid=0. Memory contents are not reset.
- Address-phase accept: HSEL & HREADYIN & HTRANS[1] on a rising edge. Register addr, write, size, and the lane strobe.
- IDLE/BUSY while selected: no transfer; next cycle HREADYOUT=1, HRESP=0.
- Error check at accept, in this priority: HSIZE > log2(DATA_WIDTH/8); misaligned (HADDR mod 2**HSIZE != 0); write with address in [RO_BASE, RO_LIMIT].
  - Any error: memory is not modified. Go to ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE/accept.
  - A transfer presented during ERR2 with HREADYIN=1 is accepted normally.
- States: IDLE, DATA, ERR1, ERR2.
  - DATA stalls (HREADYOUT=0, HRESP=0) while wait counter < WAIT_STATES or wait_req=1.
  - Completes with HREADYOUT=1 on the first cycle where both are clear.
  - Zero-wait case: completes in the cycle after accept.
- Write: lane strobes follow HSIZE and HADDR low bits (little-endian). HWDATA is sampled on the completing edge and written into a pending-write register. That register commits to the array on the next edge.
- Read: array read uses the registered address. HRDATA updates on the completing data-phase cycle and holds until the next read completes.
  - Bytes under a still-pending write to the same word come from the pending register (forwarding).
  - Back-to-back write→read to the same address returns new data with no extra wait.
- wait_req is ignored outside DATA. BUSY inside a burst adds no wait.
- Reset mid-transfer: all outputs return to reset values immediately. Pending write is discarded.

Decomposition:
- Package ahb_pkg: HTRANS encodings, HRESP encodings, HSIZE encodings, state enum, lane-strobe function (size, addr → byte mask).
- Sub-module ahb_sram_array: byte-enabled synchronous RAM (one write port, one read port). Parametrised by depth and DATA_WIDTH.

Test Plan:
- Reset, then write 32'hDEADBEEF to 0x100 (WAIT_STATES=0), then read 0x100 → write completes one cycle after accept; read returns DEADBEEF with HRESP=0.
- Back-to-back NONSEQ write 0x11223344 to 0x200, immediately followed by read of 0x200 → read returns 0x11223344 via forwarding with no stall.
- Byte write 0xAA to 0x201 (HSIZE=0) over word 0x11223344 → read 0x200 returns 0x1122AA44.
- Write to 0x004 (RO window) → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1). Later read of 0x004 returns the old value.
- Misaligned halfword at 0x201, and HSIZE=3 with DATA_WIDTH=32 → both get the two-cycle ERROR response.
- WAIT_STATES=2 with wait_req high for 3 cycles → HREADYOUT low for 3 data-phase cycles, then completes. Assert HRESETn low mid-stall → HREADYOUT=1, HRESP=0 at once.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave state type and byte-lane helpers
// for the parametrised SRAM slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slaveState_e;

  // Little-endian byte-lane mask for a transfer of 2**size bytes starting
  // at byte offset addrLo within a 64-bit lane group. Callers truncate the
  // result to their own bus width; only aligned addresses reach here.
  function automatic logic [7:0] laneStrobe(input logic [2:0] size,
                                            input logic [2:0] addrLo);
    logic [7:0] base;
    case (size)
      HSIZE_BYTE:  base = 8'h01;
      HSIZE_HALF:  base = 8'h03;
      HSIZE_WORD:  base = 8'h0F;
      default:     base = 8'hFF;
    endcase
    return base << addrLo;
  endfunction

  // Low address bits that must be zero for a naturally aligned transfer.
  function automatic logic [2:0] alignMask(input logic [2:0] size);
    logic [2:0] mask;
    case (size)
      HSIZE_BYTE:  mask = 3'b000;
      HSIZE_HALF:  mask = 3'b001;
      HSIZE_WORD:  mask = 3'b011;
      default:     mask = 3'b111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Byte-enabled synchronous RAM with one write port and one read port.
// A read of the word being written in the same cycle returns the merged
// new data, so the slave only has to forward from its pending register.
module ahb_sram_array #(
  parameter int AW         = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [AW-1:0]           i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic [AW-1:0]           i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);
  import ahb_pkg::*;

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** AW;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_readWord;

  // Read word with same-cycle write bypass applied lane by lane
  always_comb begin
    w_readWord = r_mem[i_raddr];
    for (int b = 0; b < BYTES; b++) begin
      if (i_we && (i_waddr == i_raddr) && i_wstrb[b]) begin
        w_readWord[b*8 +: 8] = i_wdata[b*8 +: 8];
      end
    end
  end

  // Byte-masked write and registered read; contents are never reset
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (i_we && i_wstrb[b]) begin
        r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    r_rdata <= w_readWord;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_sram_slave.sv
// Parametrised AHB-Lite SRAM slave: byte-lane writes, a read-only window,
// fixed plus externally requested wait states, two-cycle ERROR response
// and forwarding from the pending-write register to reads.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int RO_BASE     = 'h000,
  parameter int RO_LIMIT    = 'h00F,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADYIN,
  input  logic                  wait_req,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);
  import ahb_pkg::*;

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int BYTE_AW = $clog2(BYTES);
  localparam int WORD_AW = ADDR_WIDTH - BYTE_AW;

  localparam logic [2:0]            SIZE_MAX  = 3'(BYTE_AW);
  localparam logic [2:0]            WAIT_LOAD = 3'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] RO_LO     = ADDR_WIDTH'(RO_BASE);
  localparam logic [ADDR_WIDTH-1:0] RO_SPAN   = ADDR_WIDTH'(RO_LIMIT - RO_BASE);

  slaveState_e           r_state;
  logic [WORD_AW-1:0]    r_wordAddr;
  logic                  r_write;
  logic [BYTES-1:0]      r_strb;
  logic [2:0]            r_waitCnt;
  logic [DATA_WIDTH-1:0] r_hrdata;

  logic                  r_pendValid;
  logic [WORD_AW-1:0]    r_pendAddr;
  logic [DATA_WIDTH-1:0] r_pendData;
  logic [BYTES-1:0]      r_pendStrb;

  logic                  w_dataDone;
  logic                  w_slaveReady;
  logic                  w_accept;
  logic                  w_sizeErr;
  logic                  w_alignErr;
  logic                  w_roErr;
  logic                  w_anyErr;
  logic                  w_wrComplete;
  logic                  w_rdComplete;
  logic [2:0]            w_addrLo;
  logic [BYTES-1:0]      w_strb;
  logic [WORD_AW-1:0]    w_raddr;
  logic [DATA_WIDTH-1:0] w_ram;
  logic [DATA_WIDTH-1:0] w_fwd;

  // Data phase finishes once the fixed wait count has drained and nobody
  // outside is asking for a stall
  assign w_dataDone   = (r_state == ST_DATA) && (r_waitCnt == 3'd0) && !wait_req;
  assign w_slaveReady = (r_state == ST_IDLE) || (r_state == ST_ERR2) || w_dataDone;
  assign w_accept     = HSEL && HREADYIN && w_slaveReady &&
                        ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign w_wrComplete = w_dataDone && r_write;
  assign w_rdComplete = w_dataDone && !r_write;

  // The read-only window test uses an unsigned offset so that a window
  // starting at address zero needs no separate lower-bound compare
  assign w_sizeErr  = HSIZE > SIZE_MAX;
  assign w_alignErr = |(HADDR[2:0] & alignMask(HSIZE));
  assign w_roErr    = HWRITE && ((HADDR - RO_LO) <= RO_SPAN);
  assign w_anyErr   = w_sizeErr || w_alignErr || w_roErr;

  assign w_addrLo = 3'(HADDR[BYTE_AW-1:0]);
  assign w_strb   = BYTES'(laneStrobe(HSIZE, w_addrLo));

  // Read the new address on accept so zero-wait reads have data in the
  // following cycle; otherwise keep re-reading the held address so that
  // commits during a stall are picked up
  assign w_raddr = w_accept ? HADDR[ADDR_WIDTH-1:BYTE_AW] : r_wordAddr;

  ahb_sram_array #(
    .AW         (WORD_AW),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .i_clk   (HCLK),
    .i_we    (r_pendValid),
    .i_waddr (r_pendAddr),
    .i_wdata (r_pendData),
    .i_wstrb (r_pendStrb),
    .i_raddr (w_raddr),
    .o_rdata (w_ram)
  );

  // Overlay bytes of a not-yet-committed write to the same word
  always_comb begin
    w_fwd = w_ram;
    for (int b = 0; b < BYTES; b++) begin
      if (r_pendValid && (r_pendAddr == r_wordAddr) && r_pendStrb[b]) begin
        w_fwd[b*8 +: 8] = r_pendData[b*8 +: 8];
      end
    end
  end

  // Transfer FSM: address-phase capture, wait counting, error sequencing
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_IDLE;
      r_wordAddr <= '0;
      r_write    <= 1'b0;
      r_strb     <= '0;
      r_waitCnt  <= 3'd0;
      r_hrdata   <= '0;
    end else begin
      if (w_rdComplete) begin
        r_hrdata <= w_fwd;
      end
      if (w_accept) begin
        r_wordAddr <= HADDR[ADDR_WIDTH-1:BYTE_AW];
        r_write    <= HWRITE;
        r_strb     <= w_strb;
        r_waitCnt  <= WAIT_LOAD;
        r_state    <= w_anyErr ? ST_ERR1 : ST_DATA;
      end else begin
        case (r_state)
          ST_DATA: begin
            if (w_dataDone) begin
              r_state <= ST_IDLE;
            end else if (r_waitCnt != 3'd0) begin
              r_waitCnt <= r_waitCnt - 3'd1;
            end
          end
          ST_ERR1: r_state <= ST_ERR2;
          ST_ERR2: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Pending-write register: captures HWDATA on completion, commits next edge
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pendValid <= 1'b0;
      r_pendAddr  <= '0;
      r_pendData  <= '0;
      r_pendStrb  <= '0;
    end else begin
      r_pendValid <= w_wrComplete;
      if (w_wrComplete) begin
        r_pendAddr <= r_wordAddr;
        r_pendData <= HWDATA;
        r_pendStrb <= r_strb;
      end
    end
  end

  assign HREADYOUT = (r_state == ST_ERR1) ? 1'b0 :
                     (r_state == ST_DATA) ? w_dataDone : 1'b1;
  assign HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = w_rdComplete ? w_fwd : r_hrdata;

endmodule
